ray_tracer_mb: RTL and testbench

RAY_TRACER_MB -- requirements
Module: ray_tracer_mb

---
 rtl/ray_tracer_mb_pkg.sv | 37 +++
 rtl/ray_tracer_mb_watchdog.sv | 45 ++++
 rtl/ray_tracer_mb.sv | 232 +++++++++++++++++++++++
 tb/tb_ray_tracer_mb.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ray_tracer_mb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ray_tracer_mb_pkg
//  Description : Shared types for the multi-bounce ray tracer control block.
//                fp24 is 1 sign, 7 exponent, 16 mantissa bits. A colour is
//                black when all three exponents are zero.
//  Revision    : 1.0 - initial release
// ============================================================================
package ray_tracer_mb_pkg;

    typedef struct packed {
        logic        sign;
        logic [6:0]  exp;
        logic [15:0] man;
    } fp24;

    typedef struct packed {
        fp24 x;
        fp24 y;
        fp24 z;
    } fp24_vec3;

    typedef struct packed {
        fp24 r;
        fp24 g;
        fp24 b;
    } fp24_color;

    // 1.0 in every channel (exponent bias 63, zero mantissa).
    localparam logic [71:0] ONE_COLOR = 72'h3f0000_3f0000_3f0000;

    function automatic logic is_black(input fp24_color c);
        return (c.r.exp == 7'd0) && (c.g.exp == 7'd0) && (c.b.exp == 7'd0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ray_tracer_mb_watchdog.sv
`default_nettype none
// ============================================================================
//  Module      : req_watchdog
//  Description : Per-request wait counter. start clears and arms it, stop
//                disarms it. expired holds high once TIMEOUT cycles have
//                elapsed since start, until the next start or stop.
//  Ports       : clk, rst_n (async active-low), start, stop -> expired
//  Revision    : 1.0 - initial release
// ============================================================================
module req_watchdog #(
    parameter int TIMEOUT = 4096
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic stop,
    output logic expired
);

    localparam int              c_cw    = $clog2(TIMEOUT + 1);
    localparam logic [c_cw-1:0] c_limit = c_cw'(TIMEOUT);

    logic [c_cw-1:0] r_cnt;
    logic            r_run;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_run <= 1'b0;
        end else if (start) begin
            r_cnt <= '0;
            r_run <= 1'b1;
        end else if (stop) begin
            r_cnt <= '0;
            r_run <= 1'b0;
        end else if (r_run && (r_cnt != c_limit)) begin
            // Saturate so expired stays asserted until the FSM reacts.
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign expired = r_run && (r_cnt == c_limit);

endmodule
`default_nettype wire

// File: rtl/ray_tracer_mb.sv
`default_nettype none
// ============================================================================
//  Module      : ray_tracer_mb
//  Description : Bounce-loop controller for one ray at a time. Accepts a
//                primary ray, alternates intersector / reflector requests
//                until a miss, the bounce limit, a black throughput or a
//                timeout, then presents the accumulated light.
//  Ports       : in_*   ray request handshake and payload
//                out_*  result handshake and payload
//                intx_* intersector request / response
//                rflx_* reflector request / response
//  Revision    : 1.0 - initial release
// ============================================================================
module ray_tracer_mb
    import ray_tracer_mb_pkg::*;
#(
    parameter int MAX_BOUNCES = 8,
    parameter int TIMEOUT     = 4096,
    parameter int EARLY_EXIT  = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [71:0]                    in_origin,
    input  logic [71:0]                    in_dir,
    input  logic [10:0]                    in_pixel_h,
    input  logic [9:0]                     in_pixel_v,
    input  logic [$clog2(MAX_BOUNCES):0]   in_max_bounces,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [71:0]                    out_color,
    output logic [10:0]                    out_pixel_h,
    output logic [9:0]                     out_pixel_v,
    output logic [$clog2(MAX_BOUNCES):0]   out_bounces,
    output logic                           out_error,
    output logic                           intx_valid,
    output logic [71:0]                    intx_origin,
    output logic [71:0]                    intx_dir,
    input  logic                           intx_done,
    input  logic                           intx_hit_any,
    output logic                           rflx_valid,
    output logic [71:0]                    rflx_dir,
    output logic [71:0]                    rflx_color,
    output logic [71:0]                    rflx_light,
    input  logic                           rflx_done,
    input  logic [71:0]                    rflx_new_dir,
    input  logic [71:0]                    rflx_new_origin,
    input  logic [71:0]                    rflx_new_color,
    input  logic [71:0]                    rflx_new_light
);

    localparam int c_bw = $clog2(MAX_BOUNCES) + 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_INTX    = 2'd1,
        S_REFLECT = 2'd2,
        S_EMIT    = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_next;

    logic [71:0]     r_origin;
    logic [71:0]     r_dir;
    fp24_color       r_color;
    logic [71:0]     r_light;
    logic [10:0]     r_pixel_h;
    logic [9:0]      r_pixel_v;
    logic [c_bw-1:0] r_limit;
    logic [c_bw-1:0] r_bounces;
    logic            r_error;
    logic            r_in_ready;
    logic            r_first;       // first cycle in a wait state: request not yet issued
    logic            r_intx_valid;
    logic            r_rflx_valid;

    logic            w_accept;
    logic            w_intx_acc;
    logic            w_rflx_acc;
    logic            w_timeout;
    logic            w_expired;
    logic            w_wait_live;   // request issued and its pulse has passed
    logic [c_bw-1:0] w_limit;
    logic [c_bw-1:0] w_bounces_inc;

    // Effective limit: clamp to MAX_BOUNCES, and a zero request means one bounce.
    always_comb begin
        w_limit = in_max_bounces;
        if (in_max_bounces > c_bw'(MAX_BOUNCES)) begin
            w_limit = c_bw'(MAX_BOUNCES);
        end
        if (in_max_bounces == '0) begin
            w_limit = c_bw'(1);
        end
    end

    assign w_bounces_inc = r_bounces + c_bw'(1);
    // A done arriving alongside its own request pulse is not a response.
    assign w_wait_live   = !r_first && !r_intx_valid && !r_rflx_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_accept   = 1'b0;
        w_intx_acc = 1'b0;
        w_rflx_acc = 1'b0;
        w_timeout  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (in_valid && r_in_ready) begin
                    w_accept = 1'b1;
                    w_next   = S_INTX;
                end
            end
            S_INTX: begin
                if (w_wait_live) begin
                    if (intx_done) begin
                        w_intx_acc = 1'b1;
                        w_next     = intx_hit_any ? S_REFLECT : S_EMIT;
                    end else if (w_expired) begin
                        w_timeout = 1'b1;
                        w_next    = S_EMIT;
                    end
                end
            end
            S_REFLECT: begin
                if (w_wait_live) begin
                    if (rflx_done) begin
                        w_rflx_acc = 1'b1;
                        if ((w_bounces_inc == r_limit) ||
                            ((EARLY_EXIT != 0) && is_black(fp24_color'(rflx_new_color)))) begin
                            w_next = S_EMIT;
                        end else begin
                            w_next = S_INTX;
                        end
                    end else if (w_expired) begin
                        w_timeout = 1'b1;
                        w_next    = S_EMIT;
                    end
                end
            end
            S_EMIT: begin
                if (out_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_origin     <= '0;
            r_dir        <= '0;
            r_color      <= '0;
            r_light      <= '0;
            r_pixel_h    <= '0;
            r_pixel_v    <= '0;
            r_limit      <= '0;
            r_bounces    <= '0;
            r_error      <= 1'b0;
            r_in_ready   <= 1'b0;
            r_first      <= 1'b0;
            r_intx_valid <= 1'b0;
            r_rflx_valid <= 1'b0;
        end else begin
            r_in_ready   <= (w_next == S_IDLE);
            r_first      <= (w_next != r_state) &&
                            ((w_next == S_INTX) || (w_next == S_REFLECT));
            r_intx_valid <= r_first && (r_state == S_INTX);
            r_rflx_valid <= r_first && (r_state == S_REFLECT);
            if (w_accept) begin
                r_origin  <= in_origin;
                r_dir     <= in_dir;
                r_pixel_h <= in_pixel_h;
                r_pixel_v <= in_pixel_v;
                r_limit   <= w_limit;
                r_light   <= '0;
                r_color   <= fp24_color'(ONE_COLOR);
                r_bounces <= '0;
                r_error   <= 1'b0;
            end
            if (w_rflx_acc) begin
                r_origin  <= rflx_new_origin;
                r_dir     <= rflx_new_dir;
                r_color   <= fp24_color'(rflx_new_color);
                r_light   <= rflx_new_light;
                r_bounces <= w_bounces_inc;
            end
            if (w_timeout) begin
                r_error <= 1'b1;
                r_light <= '0;
            end
        end
    end

    req_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (r_first),
        .stop    ((r_state == S_IDLE) || (r_state == S_EMIT)),
        .expired (w_expired)
    );

    assign in_ready    = r_in_ready;
    assign out_valid   = (r_state == S_EMIT);
    assign out_color   = r_light;
    assign out_pixel_h = r_pixel_h;
    assign out_pixel_v = r_pixel_v;
    assign out_bounces = r_bounces;
    assign out_error   = r_error;
    assign intx_valid  = r_intx_valid;
    assign intx_origin = r_origin;
    assign intx_dir    = r_dir;
    assign rflx_valid  = r_rflx_valid;
    assign rflx_dir    = r_dir;
    assign rflx_color  = r_color;
    assign rflx_light  = r_light;

endmodule
`default_nettype wire

// File: tb/tb_ray_tracer_mb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ray_tracer_mb
//  Description : Directed bench for ray_tracer_mb with scripted intersector
//                and reflector responses (TIMEOUT shortened to 16).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ray_tracer_mb;

    localparam int          MB  = 8;
    localparam int          TO  = 16;
    localparam logic [71:0] ONE = 72'h3f0000_3f0000_3f0000;
    localparam logic [71:0] L1  = 72'h3f0000_3f0000_3f0000;
    localparam logic [71:0] L2  = 72'h3e4000_3d2000_3c1000;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [71:0] in_origin;
    logic [71:0] in_dir;
    logic [10:0] in_pixel_h;
    logic [9:0]  in_pixel_v;
    logic [3:0]  in_max_bounces;
    logic        out_valid;
    logic        out_ready;
    logic [71:0] out_color;
    logic [10:0] out_pixel_h;
    logic [9:0]  out_pixel_v;
    logic [3:0]  out_bounces;
    logic        out_error;
    logic        intx_valid;
    logic [71:0] intx_origin;
    logic [71:0] intx_dir;
    logic        intx_done;
    logic        intx_hit_any;
    logic        rflx_valid;
    logic [71:0] rflx_dir;
    logic [71:0] rflx_color;
    logic [71:0] rflx_light;
    logic        rflx_done;
    logic [71:0] rflx_new_dir;
    logic [71:0] rflx_new_origin;
    logic [71:0] rflx_new_color;
    logic [71:0] rflx_new_light;

    int n_checks = 0;
    int n_errors = 0;
    int n_rflx   = 0;

    // Expected request payload of the ray in flight.
    logic [71:0] m_origin, m_dir, m_color, m_light;

    ray_tracer_mb #(
        .MAX_BOUNCES (MB),
        .TIMEOUT     (TO),
        .EARLY_EXIT  (1)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_origin       (in_origin),
        .in_dir          (in_dir),
        .in_pixel_h      (in_pixel_h),
        .in_pixel_v      (in_pixel_v),
        .in_max_bounces  (in_max_bounces),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_color       (out_color),
        .out_pixel_h     (out_pixel_h),
        .out_pixel_v     (out_pixel_v),
        .out_bounces     (out_bounces),
        .out_error       (out_error),
        .intx_valid      (intx_valid),
        .intx_origin     (intx_origin),
        .intx_dir        (intx_dir),
        .intx_done       (intx_done),
        .intx_hit_any    (intx_hit_any),
        .rflx_valid      (rflx_valid),
        .rflx_dir        (rflx_dir),
        .rflx_color      (rflx_color),
        .rflx_light      (rflx_light),
        .rflx_done       (rflx_done),
        .rflx_new_dir    (rflx_new_dir),
        .rflx_new_origin (rflx_new_origin),
        .rflx_new_color  (rflx_new_color),
        .rflx_new_light  (rflx_new_light)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (rflx_valid === 1'b1) n_rflx++;

    initial begin
        #100000;
        $display("FAIL global_timeout: observed hang expected finish");
        $fatal(1, "bench time limit");
    end

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic send_ray(input logic [71:0] o, input logic [71:0] d,
                            input logic [10:0] h, input logic [9:0] v, input logic [3:0] lim);
        int k = 0;
        while (in_ready !== 1'b1 && k < 50) begin tick(); k++; end
        check("send_ready", in_ready, 1);
        in_origin = o; in_dir = d; in_pixel_h = h; in_pixel_v = v; in_max_bounces = lim;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        m_origin = o; m_dir = d; m_color = ONE; m_light = '0;
    endtask

    task automatic do_intx(input logic hit, input int d);
        int k = 0;
        while (intx_valid !== 1'b1 && k < 60) begin tick(); k++; end
        check("intx_pulse", intx_valid, 1);
        check("intx_origin", intx_origin, m_origin);
        check("intx_dir", intx_dir, m_dir);
        repeat (d) tick();
        intx_hit_any = hit; intx_done = 1'b1;
        tick();
        intx_done = 1'b0; intx_hit_any = 1'b0;
    endtask

    task automatic do_rflx(input int d, input logic [71:0] col, input logic [71:0] light,
                           input logic [71:0] ndir, input logic [71:0] norg);
        int k = 0;
        while (rflx_valid !== 1'b1 && k < 60) begin tick(); k++; end
        check("rflx_pulse", rflx_valid, 1);
        check("rflx_dir", rflx_dir, m_dir);
        check("rflx_color", rflx_color, m_color);
        check("rflx_light", rflx_light, m_light);
        repeat (d) tick();
        rflx_new_color = col; rflx_new_light = light; rflx_new_dir = ndir; rflx_new_origin = norg;
        rflx_done = 1'b1;
        tick();
        rflx_done = 1'b0;
        m_color = col; m_light = light; m_dir = ndir; m_origin = norg;
    endtask

    task automatic wait_out();
        int k = 0;
        while (out_valid !== 1'b1 && k < 100) begin tick(); k++; end
        check("out_valid_seen", out_valid, 1);
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("post_hs_out_valid", out_valid, 0);
        check("post_hs_in_ready", in_ready, 1);
    endtask

    initial begin
        int base;
        int k;
        rst_n = 1'b0; in_valid = 1'b0; in_origin = '0; in_dir = '0; in_pixel_h = '0;
        in_pixel_v = '0; in_max_bounces = '0; out_ready = 1'b0; intx_done = 1'b0;
        intx_hit_any = 1'b0; rflx_done = 1'b0; rflx_new_dir = '0; rflx_new_origin = '0;
        rflx_new_color = '0; rflx_new_light = '0;
        m_origin = '0; m_dir = '0; m_color = '0; m_light = '0;

        // Reset state
        repeat (2) tick();
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_color", out_color, 0);
        check("rst_out_bounces", out_bounces, 0);
        check("rst_out_error", out_error, 0);
        check("rst_intx_valid", intx_valid, 0);
        rst_n = 1'b1;
        tick();
        check("rel_in_ready", in_ready, 1);

        // Zero-latency miss; done coincident with the pulse is ignored
        send_ray(72'h111, 72'h222, 11'd5, 10'd6, 4'd1);
        check("n0_in_ready", in_ready, 0);
        tick();
        check("intx_pulse_timing", intx_valid, 1);
        intx_done = 1'b1; intx_hit_any = 1'b0;
        tick();
        check("same_cycle_done_ignored", out_valid, 0);
        tick();
        intx_done = 1'b0;
        check("min_latency_3", out_valid, 1);
        check("t1_color", out_color, 0);
        check("t1_pix_h", out_pixel_h, 11'd5);
        handshake();

        // Miss on first intersection after 5 cycles, tag echoed
        send_ray(72'h0a0b0c, 72'h0d0e0f, 11'd1919, 10'd1079, 4'd3);
        do_intx(1'b0, 5);
        wait_out();
        check("miss_color", out_color, 0);
        check("miss_bounces", out_bounces, 0);
        check("miss_error", out_error, 0);
        check("miss_pix_h", out_pixel_h, 11'd1919);
        check("miss_pix_v", out_pixel_v, 10'd1079);
        handshake();

        // Limit 3, every intersection hits
        base = n_rflx;
        send_ray(72'h1, 72'h2, 11'd10, 10'd20, 4'd3);
        for (int i = 0; i < 3; i++) begin
            do_intx(1'b1, 2);
            do_rflx(1, ONE, L1, 72'h200 + 72'(i), 72'h100 + 72'(i));
        end
        wait_out();
        check("lim3_bounces", out_bounces, 3);
        check("lim3_color", out_color, L1);
        check("lim3_error", out_error, 0);
        check("lim3_pulses", 72'(n_rflx - base), 3);
        // Back-pressure: outputs hold while out_ready is low
        for (int i = 0; i < 10; i++) begin
            tick();
            check("stall_out_valid", out_valid, 1);
            check("stall_in_ready", in_ready, 0);
            check("stall_color", out_color, L1);
            check("stall_bounces", out_bounces, 3);
        end
        handshake();

        // Black throughput on second bounce ends the ray early
        base = n_rflx;
        send_ray(72'h3, 72'h4, 11'd11, 10'd21, 4'd8);
        do_intx(1'b1, 1);
        do_rflx(1, 72'h010000_000000_000000, L1, 72'h31, 72'h32);
        do_intx(1'b1, 1);
        do_rflx(1, 72'h80ffff_00ffff_80ffff, L2, 72'h33, 72'h34);
        wait_out();
        check("early_bounces", out_bounces, 2);
        check("early_color", out_color, L2);
        check("early_pulses", 72'(n_rflx - base), 2);
        handshake();

        // Limit 0 behaves as 1
        send_ray(72'h5, 72'h6, 11'd12, 10'd22, 4'd0);
        do_intx(1'b1, 1);
        do_rflx(1, ONE, L2, 72'h41, 72'h42);
        wait_out();
        check("lim0_bounces", out_bounces, 1);
        check("lim0_color", out_color, L2);
        handshake();

        // Limit 12 clamps to MAX_BOUNCES
        base = n_rflx;
        send_ray(72'h7, 72'h8, 11'd13, 10'd23, 4'd12);
        for (int i = 0; i < MB; i++) begin
            do_intx(1'b1, 1);
            do_rflx(1, ONE, L1 + 72'(i), 72'h50 + 72'(i), 72'h60 + 72'(i));
        end
        wait_out();
        check("clamp_bounces", out_bounces, 8);
        check("clamp_color", out_color, L1 + 72'd7);
        check("clamp_pulses", 72'(n_rflx - base), 8);
        handshake();

        // Timeout on the second intersection request
        send_ray(72'h9, 72'ha, 11'd14, 10'd24, 4'd4);
        do_intx(1'b1, 1);
        do_rflx(1, ONE, L1, 72'h71, 72'h72);
        k = 0;
        while (intx_valid !== 1'b1 && k < 60) begin tick(); k++; end
        check("tmo_pulse", intx_valid, 1);
        k = 0;
        while (out_valid !== 1'b1 && k < 40) begin tick(); k++; end
        check("tmo_latency_17_18", (k >= 17 && k <= 18), 1);
        check("tmo_error", out_error, 1);
        check("tmo_color", out_color, 0);
        check("tmo_bounces", out_bounces, 1);
        handshake();

        // Reset mid-REFLECT, then a stray reflector done
        send_ray(72'hb, 72'hc, 11'd15, 10'd25, 4'd4);
        do_intx(1'b1, 1);
        k = 0;
        while (rflx_valid !== 1'b1 && k < 60) begin tick(); k++; end
        check("rst_rflx_pulse", rflx_valid, 1);
        tick();
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_in_ready", in_ready, 0);
        check("mid_rst_rflx_valid", rflx_valid, 0);
        check("mid_rst_bounces", out_bounces, 0);
        check("mid_rst_color", out_color, 0);
        check("mid_rst_pix_h", out_pixel_h, 0);
        check("mid_rst_error", out_error, 0);
        tick();
        rst_n = 1'b1;
        rflx_new_color = ONE; rflx_new_light = L2; rflx_done = 1'b1;
        tick();
        check("stray_in_ready", in_ready, 1);
        check("stray_out_valid", out_valid, 0);
        tick();
        rflx_done = 1'b0;
        check("stray_out_valid2", out_valid, 0);
        check("stray_intx_valid", intx_valid, 0);
        check("stray_bounces", out_bounces, 0);

        send_ray(72'hd, 72'he, 11'd77, 10'd33, 4'd2);
        do_intx(1'b1, 1);
        do_rflx(1, ONE, L2, 72'h81, 72'h82);
        do_intx(1'b0, 3);
        wait_out();
        check("after_rst_bounces", out_bounces, 1);
        check("after_rst_color", out_color, L2);
        check("after_rst_error", out_error, 0);
        check("after_rst_pix_h", out_pixel_h, 11'd77);
        check("after_rst_pix_v", out_pixel_v, 10'd33);
        handshake();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
